mux4_rr_sequencer: RTL and testbench

Round-robin select sequencer sitting directly upstream of the 2-bit 4-to-1 mux. It arbitrates among four requesting channels (u, v, w, x) and drives the mux select so that one channel's 2-bit value is presented on the mux output at a time. Each grant is held until a downstream consumer acknowledges it, the requester withdraws, or a timeout expires. `s` connects straight to the mux `s` input.

---
 rtl/mux4_rr_sequencer.sv | 149 ++++++++++++++
 tb/tb_mux4_rr_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sequencer.sv
// Round-robin select sequencer for a 2-bit 4-to-1 mux: grants one of four
// requesters, holds the grant until ack, withdrawal or timeout, counts transfers.
module mux4_rr_sequencer #(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] s,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout,
  output logic [7:0] xfer_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] s_q, s_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic [7:0] xfer_q, xfer_d;
  logic [7:0] wait_q, wait_d;

  pick_t pick_idle;
  pick_t pick_ack;

  // Scan last+1 .. last+4 (mod 4); the most recently served channel comes last.
  function automatic pick_t rr_pick(input logic [1:0] last, input logic [3:0] r);
    pick_t      p;
    logic [1:0] c;
    p = '0;
    for (int k = 1; k <= 4; k++) begin
      c = last + 2'(k);
      if (!p.found && r[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  assign pick_idle = rr_pick(last_q, req);
  assign pick_ack  = rr_pick(s_q, req);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    s_d       = s_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    xfer_d    = xfer_q;
    wait_d    = wait_q;

    unique case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          s_d     = pick_idle.idx;
          grant_d = onehot(pick_idle.idx);
          valid_d = 1'b1;
          wait_d  = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (ack) begin
          last_d = s_q;
          if (xfer_q != 8'hFF) xfer_d = xfer_q + 8'd1;
          // Back-to-back grant searches from the channel just served.
          if (pick_ack.found) begin
            s_d     = pick_ack.idx;
            grant_d = onehot(pick_ack.idx);
            valid_d = 1'b1;
            wait_d  = '0;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (!req[s_q]) begin
          grant_d = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          last_d    = s_q;
          timeout_d = 1'b1;
          grant_d   = '0;
          valid_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 2'b11;
      s_q       <= 2'b00;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      xfer_q    <= '0;
      wait_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      s_q       <= s_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      xfer_q    <= xfer_d;
      wait_q    <= wait_d;
    end
  end

  assign s          = s_q;
  assign grant      = grant_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Self-checking bench for mux4_rr_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a model.
module tb_mux4_rr_sequencer;

  localparam int MAX_WAIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic [1:0] s;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;
  logic [7:0] xfer_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: grant described by owner, edge of issue and history.
  int m_valid, m_s, m_last, m_cnt, m_timeout, m_cyc, m_gcyc;

  mux4_rr_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .s          (s),
    .grant      (grant),
    .valid      (valid),
    .timeout    (timeout),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_s = 0; m_last = 3; m_cnt = 0; m_timeout = 0; m_cyc = 0; m_gcyc = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    int w;
    m_cyc++;
    m_timeout = 0;
    w = pick(m_last, r);
    if (m_valid == 0) begin
      if (w >= 0) begin m_s = w; m_valid = 1; m_gcyc = m_cyc; end
    end else if (a) begin
      m_last = m_s;
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      w = pick(m_last, r);
      if (w >= 0) begin m_s = w; m_gcyc = m_cyc; end
      else m_valid = 0;
    end else if (!r[m_s]) begin
      m_valid = 0;
    end else if (m_cyc - m_gcyc == MAX_WAIT) begin
      m_last = m_s; m_timeout = 1; m_valid = 0;
    end
  endtask

  // Single compare process: model advances on each edge, outputs checked 1ns later.
  always begin
    @(posedge clk);
    if (reset) model_reset();
    else model_step(req, ack);
    #1;
    if (chk_en) begin
      check("model_s",       32'(s),          (m_valid != 0 || m_cyc > 0) ? 32'(m_s) : 32'(s));
      check("model_valid",   32'(valid),      32'(m_valid));
      check("model_grant",   32'(grant),      m_valid != 0 ? (32'd1 << m_s) : 32'd0);
      check("model_timeout", 32'(timeout),    32'(m_timeout));
      check("model_xfer",    32'(xfer_count), 32'(m_cnt));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic a);
    @(negedge clk);
    req = r;
    ack = a;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    ack   = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rot_exp [5];
    reset = 1'b1;
    req   = '0;
    ack   = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_s",     32'(s),     0);
    check("rst_grant", 32'(grant), 0);
    check("rst_xfer",  32'(xfer_count), 0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle hold with no requests.
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'b0);
      check("idle_valid", 32'(valid), 0);
      check("idle_s",     32'(s),     0);
      check("idle_xfer",  32'(xfer_count), 0);
    end

    // Full rotation with immediate acks.
    rot_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1111, 1'b1);
      if (i < 5) check("rot_s", 32'(s), 32'(rot_exp[i]));
      check("rot_valid", 32'(valid), 1);
    end
    check("rot_xfer", 32'(xfer_count), 5);

    // Skip non-requesters, then a late requester on channel 0.
    do_reset();
    cyc(4'b1010, 1'b0); check("skip_s0", 32'(s), 1);
    cyc(4'b1010, 1'b1); check("skip_s1", 32'(s), 3);
    cyc(4'b1010, 1'b1); check("skip_s2", 32'(s), 1);
    cyc(4'b1010, 1'b1); check("skip_s3", 32'(s), 3);
    cyc(4'b1011, 1'b1); check("fair_s0", 32'(s), 0);
    cyc(4'b1011, 1'b1); check("fair_s1", 32'(s), 1);
    check("fair_xfer", 32'(xfer_count), 5);

    // Withdrawal leaves last untouched.
    do_reset();
    cyc(4'b0100, 1'b0); check("wd_s", 32'(s), 2);
    cyc(4'b0000, 1'b0);
    check("wd_valid", 32'(valid), 0);
    check("wd_xfer",  32'(xfer_count), 0);
    cyc(4'b1111, 1'b0); check("wd_next_s", 32'(s), 0);

    // Timeout after MAX_WAIT un-acked edges, then immediate re-grant.
    do_reset();
    cyc(4'b0001, 1'b0); check("to_grant", 32'(valid), 1);
    for (int i = 1; i <= MAX_WAIT; i++) begin
      cyc(4'b0001, 1'b0);
      check("to_pulse", 32'(timeout), (i == MAX_WAIT) ? 1 : 0);
      check("to_valid", 32'(valid),   (i == MAX_WAIT) ? 0 : 1);
    end
    cyc(4'b0001, 1'b0);
    check("to_regrant_valid",   32'(valid),   1);
    check("to_regrant_timeout", 32'(timeout), 0);

    // Async reset mid-grant on channel 2.
    do_reset();
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b1);
    cyc(4'b0100, 1'b0);
    check("ar_pre_s", 32'(s), 2);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("ar_valid", 32'(valid), 0);
    check("ar_grant", 32'(grant), 0);
    check("ar_s",     32'(s),     0);
    check("ar_xfer",  32'(xfer_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r;
      logic       a;
      r = 4'($urandom_range(0, 15));
      if (i % 200 < 60) r = 4'b0001 << (i % 4);
      a = ($urandom_range(0, 99) < ((i % 400 < 200) ? 50 : 8));
      cyc(r, a);
    end

    // Saturation of the transfer counter.
    do_reset();
    for (int i = 0; i < 301; i++) cyc(4'b1111, 1'b1);
    check("sat_xfer", 32'(xfer_count), 255);
    for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b1);
    check("sat_hold", 32'(xfer_count), 255);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
